// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared SPI definitions used by spi_master and spi_slave:
//                default word width, the idle fill word and the slave
//                frame-state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Default bits per SPI word (MSB first on the wire).
    localparam int SPI_DATA_W = 8;

    // Word shifted out by a responder when nothing has been queued.
    localparam logic [7:0] SPI_IDLE_BYTE = 8'h00;

    // Slave frame state: waiting for select, or inside a selected frame.
    typedef enum logic [0:0] {
        SLV_IDLE   = 1'b0,
        SLV_ACTIVE = 1'b1
    } slv_state_e;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Multi-flop synchronizer for an asynchronous pin, followed by
//                one history flop so rising/falling edges of the synchronized
//                level can be detected in the clk domain.
//  Ports       : clk_i    - system clock
//                rst_ni   - synchronous active-low reset
//                d_i      - asynchronous input pin
//                q_o      - synchronized level
//                rise_o   - synchronized level went 0 -> 1 (one cycle)
//                fall_o   - synchronized level went 1 -> 0 (one cycle)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   STAGES    = 2,     // synchronizer depth, at least 2
    parameter logic RESET_VAL = 1'b0   // level assumed while in reset
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    // Edges are combinational off the last stage so the consuming register
    // updates exactly STAGES+1 clocks after the pin moves.
    assign q_o    = sync_q[STAGES-1];
    assign rise_o =  sync_q[STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[STAGES-1] &  hist_q;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : SPI mode-0 (CPOL=0, CPHA=0) responder. Oversamples the
//                master's SSEL/SCLK/MOSI in the clk domain, assembles
//                received words and shifts out words from a one-entry
//                transmit holding buffer.
//  Ports       : clk_i      - system clock, rising edge
//                rst_ni     - synchronous active-low reset
//                ssel_i     - slave select, active low, asynchronous
//                sclk_i     - serial clock, idle low, asynchronous
//                mosi_i     - serial data in, asynchronous
//                miso_o     - serial data out, released (z) when deselected
//                tx_data_i  - next word to transmit
//                tx_load_i  - capture tx_data_i while tx_ready_o is high
//                tx_ready_o - holding buffer empty
//                rx_data_o  - last complete received word
//                rx_valid_o - one-cycle strobe, rx_data_o updated
//                busy_o     - frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_pkg::*;
#(
    parameter int                DATA_W      = SPI_DATA_W,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_BYTE   = DATA_W'(SPI_IDLE_BYTE)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ssel_i,
    input  logic              sclk_i,
    input  logic              mosi_i,
    output logic              miso_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_load_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o
);

    localparam int             CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    // ------------------------------------------------------------------
    // Pin synchronizers
    // ------------------------------------------------------------------
    logic w_ssel_rise, w_ssel_fall, w_ssel_lvl;
    logic w_sclk_rise, w_sclk_fall, w_sclk_lvl;
    logic w_mosi_s, w_mosi_rise, w_mosi_fall;
    logic w_unused_sync;

    // The SSEL chain resets to "selected" so that a master still holding
    // SSEL low when reset is released produces no falling edge: the block
    // waits for a fresh select before taking part in a frame.
    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_ssel (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (ssel_i),
        .q_o    (w_ssel_lvl),
        .rise_o (w_ssel_rise),
        .fall_o (w_ssel_fall)
    );

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_sclk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (sclk_i),
        .q_o    (w_sclk_lvl),
        .rise_o (w_sclk_rise),
        .fall_o (w_sclk_fall)
    );

    // MOSI uses the same depth as SCLK so the sampled bit lines up with the
    // detected SCLK rising edge; only its level is consumed.
    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_mosi (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (mosi_i),
        .q_o    (w_mosi_s),
        .rise_o (w_mosi_rise),
        .fall_o (w_mosi_fall)
    );

    assign w_unused_sync = w_mosi_rise ^ w_mosi_fall ^ w_ssel_lvl ^ w_sclk_lvl;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    slv_state_e        state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_data_q,  rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] hold_q,     hold_d;
    logic              full_q,     full_d;

    logic [DATA_W-1:0] w_tx_next;
    logic              w_consume;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= SLV_IDLE;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            hold_q     <= '0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        hold_d     = hold_q;
        full_d     = full_q;
        w_consume  = 1'b0;

        // Word to launch at a word boundary: always the buffer contents as
        // they stand this cycle, even if a new load lands in the same cycle.
        w_tx_next  = full_q ? hold_q : IDLE_BYTE;

        case (state_q)
            SLV_IDLE: begin
                if (w_ssel_fall) begin
                    state_d    = SLV_ACTIVE;
                    cnt_d      = '0;
                    rx_shift_d = '0;
                    tx_shift_d = w_tx_next;
                    w_consume  = 1'b1;
                end
            end

            SLV_ACTIVE: begin
                if (w_ssel_rise) begin
                    // Deselect: drop any partial word silently.
                    state_d    = SLV_IDLE;
                    cnt_d      = '0;
                    rx_shift_d = '0;
                end else begin
                    if (w_sclk_rise) begin
                        rx_shift_d = {rx_shift_q[DATA_W-2:0], w_mosi_s};
                        if (cnt_q == CNT_LAST) begin
                            rx_data_d  = rx_shift_d;
                            rx_valid_d = 1'b1;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    // A falling edge with the counter at zero follows the
                    // last bit of a word: start the next word instead of
                    // shifting, so back-to-back words need no gap.
                    if (w_sclk_fall) begin
                        if (cnt_q != '0) begin
                            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                        end else begin
                            tx_shift_d = w_tx_next;
                            w_consume  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = SLV_IDLE;
            end
        endcase

        // Holding buffer: a load in the same cycle as a consumption wins,
        // leaving the buffer full with the new word.
        if (w_consume) begin
            full_d = 1'b0;
        end
        if (tx_load_i && !full_q) begin
            hold_d = tx_data_i;
            full_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign miso_o     = (state_q == SLV_ACTIVE) ? tx_shift_q[DATA_W-1] : 1'bz;
    assign tx_ready_o = ~full_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign busy_o     = (state_q == SLV_ACTIVE);

endmodule : spi_slave
`default_nettype wire
